// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared sizes and requester enum for the register-file write-back path
package regfile_pkg;

    localparam int DATA_W    = 16;
    localparam int NREGS     = 4;
    localparam int REG_IDX_W = $clog2(NREGS);

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_e;

    // B is treated as the previous winner so A takes the first tie
    localparam req_e LAST_GRANT_RST = REQ_B;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter; req[0]=A, req[1]=B
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    req_e last_q;
    req_e last_d;

    always_comb begin
        gnt[0] = req[0] & (~req[1] | (last_q == REQ_B));
        gnt[1] = req[1] & (~req[0] | (last_q == REQ_A));
        last_d = last_q;
        if (accept) begin
            last_d = gnt[1] ? REQ_B : REQ_A;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= LAST_GRANT_RST;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// rtl/regfile_wb_ctrl.sv - shares the register-file write port between A and B and tracks pending destinations
module regfile_wb_ctrl
    import regfile_pkg::*;
#(
    parameter  int DATA_W = regfile_pkg::DATA_W,
    parameter  int NREGS  = regfile_pkg::NREGS,
    localparam int IDX_W  = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [IDX_W-1:0]  a_reg,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [IDX_W-1:0]  b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              rf_we,
    output logic [IDX_W-1:0]  rf_reg,
    output logic [DATA_W-1:0] rf_data,
    input  logic              iss_valid,
    input  logic [IDX_W-1:0]  iss_reg,
    output logic              iss_ready,
    input  logic [IDX_W-1:0]  rd_reg1,
    input  logic [IDX_W-1:0]  rd_reg2,
    output logic              hazard,
    input  logic              flush,
    output logic [NREGS-1:0]  busy
);

    logic [1:0]        gnt;
    logic              rf_we_q,   rf_we_d;
    logic [IDX_W-1:0]  rf_reg_q,  rf_reg_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;
    logic [NREGS-1:0]  busy_q,    busy_d;
    logic [NREGS-1:0]  set_mask;
    logic [NREGS-1:0]  clr_mask;

    // Accept is just "someone was granted": ready implies a transfer.
    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({b_valid, a_valid}),
        .accept (|gnt),
        .gnt    (gnt)
    );

    assign a_ready = gnt[0];
    assign b_ready = gnt[1];

    always_comb begin
        rf_we_d   = 1'b0;
        rf_reg_d  = rf_reg_q;
        rf_data_d = rf_data_q;
        if (gnt[0]) begin
            rf_we_d   = 1'b1;
            rf_reg_d  = a_reg;
            rf_data_d = a_data;
        end else if (gnt[1]) begin
            rf_we_d   = 1'b1;
            rf_reg_d  = b_reg;
            rf_data_d = b_data;
        end
    end

    // A register retiring this cycle may be re-issued; set is applied after clear so it wins.
    always_comb begin
        iss_ready = ~busy_q[iss_reg] | (rf_we_q & (rf_reg_q == iss_reg));
        hazard    = busy_q[rd_reg1] | busy_q[rd_reg2];
        clr_mask  = '0;
        set_mask  = '0;
        if (rf_we_q) begin
            clr_mask[rf_reg_q] = 1'b1;
        end
        if (iss_valid && iss_ready) begin
            set_mask[iss_reg] = 1'b1;
        end
        busy_d = (busy_q & ~clr_mask) | set_mask;
        if (flush) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q   <= 1'b0;
            rf_reg_q  <= '0;
            rf_data_q <= '0;
            busy_q    <= '0;
        end else begin
            rf_we_q   <= rf_we_d;
            rf_reg_q  <= rf_reg_d;
            rf_data_q <= rf_data_d;
            busy_q    <= busy_d;
        end
    end

    assign rf_we   = rf_we_q;
    assign rf_reg  = rf_reg_q;
    assign rf_data = rf_data_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb/tb_regfile_wb_ctrl.sv - scoreboard bench for regfile_wb_ctrl against a behavioural model
module tb_regfile_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, b_valid, a_ready, b_ready;
    logic [1:0]  a_reg, b_reg;
    logic [15:0] a_data, b_data;
    logic        rf_we;
    logic [1:0]  rf_reg;
    logic [15:0] rf_data;
    logic        iss_valid, iss_ready;
    logic [1:0]  iss_reg, rd_reg1, rd_reg2;
    logic        hazard, flush;
    logic [3:0]  busy;

    regfile_wb_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
        .rf_we(rf_we), .rf_reg(rf_reg), .rf_data(rf_data),
        .iss_valid(iss_valid), .iss_reg(iss_reg), .iss_ready(iss_ready),
        .rd_reg1(rd_reg1), .rd_reg2(rd_reg2), .hazard(hazard),
        .flush(flush), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        we;
        bit [1:0]  r;
        bit [15:0] d;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    bit started = 0;

    // Reference state: what the register-file port shows now, pending set, last winner
    bit        m_we;
    bit [1:0]  m_reg;
    bit [15:0] m_data;
    bit        m_busy [4];
    bit        m_last_b;
    bit        g_a, g_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] busy_vec();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_reset();
        m_we = 0; m_reg = 0; m_data = 0; m_last_b = 1;
        for (int i = 0; i < 4; i++) m_busy[i] = 0;
        exp_q.delete();
        exp_q.push_back('{we: 1'b0, r: 2'd0, d: 16'd0});
    endtask

    task automatic cycle();
        bit   irdy;
        exp_t e;
        @(negedge clk);
        if (a_valid && b_valid) begin
            g_a = m_last_b;
            g_b = !m_last_b;
        end else begin
            g_a = a_valid;
            g_b = b_valid;
        end
        irdy = !m_busy[iss_reg] || (m_we && m_reg == iss_reg);
        chk("a_ready", a_ready, g_a);
        chk("b_ready", b_ready, g_b);
        chk("iss_ready", iss_ready, irdy);
        chk("hazard", hazard, m_busy[rd_reg1] | m_busy[rd_reg2]);
        chk("busy", busy, busy_vec());
        if (m_we) m_busy[m_reg] = 0;
        if (iss_valid && irdy) m_busy[iss_reg] = 1;
        if (flush) for (int i = 0; i < 4; i++) m_busy[i] = 0;
        if (g_a) begin
            m_we = 1; m_reg = a_reg; m_data = a_data; m_last_b = 0;
        end else if (g_b) begin
            m_we = 1; m_reg = b_reg; m_data = b_data; m_last_b = 1;
        end else begin
            m_we = 0;
        end
        e.we = m_we; e.r = m_reg; e.d = m_data;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (started) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wb_queue: got empty expected entry at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("rf_we", rf_we, e.we);
                    chk("rf_reg", rf_reg, e.r);
                    chk("rf_data", rf_data, e.d);
                end
            end
        end
    end

    task automatic idle_inputs();
        a_valid = 0; b_valid = 0; iss_valid = 0; flush = 0;
    endtask

    task automatic issue(input logic [1:0] r);
        iss_valid = 1; iss_reg = r;
        cycle();
        iss_valid = 0;
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        a_reg = 0; b_reg = 0; a_data = 0; b_data = 0;
        iss_reg = 0; rd_reg1 = 0; rd_reg2 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_rf_data", rf_data, 16'h0);
        chk("rst_busy", busy, 4'h0);
        model_reset();
        rst_n = 1;
        started = 1;

        // single requester
        a_valid = 1; a_reg = 2; a_data = 16'h1234;
        cycle();
        a_valid = 0;
        cycle();
        cycle();

        // contention: strict alternation
        a_valid = 1; b_valid = 1; a_reg = 0; b_reg = 1;
        a_data = 16'hA000; b_data = 16'hB000;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (g_a) a_data = a_data + 1;
            if (g_b) b_data = b_data + 1;
        end
        idle_inputs();
        cycle();

        // hazard on reg 1 until B writes it back
        issue(2'd1);
        rd_reg1 = 1; rd_reg2 = 0;
        cycle();
        cycle();
        b_valid = 1; b_reg = 1; b_data = 16'hBEEF;
        cycle();
        b_valid = 0;
        cycle();
        cycle();

        // WAW blocked until the pending register retires
        issue(2'd3);
        iss_valid = 1; iss_reg = 3;
        a_valid = 1; a_reg = 3; a_data = 16'h3333;
        cycle();
        a_valid = 0;
        cycle();
        iss_valid = 0;
        cycle();

        // flush overrides a simultaneous issue
        issue(2'd0);
        issue(2'd1);
        flush = 1; iss_valid = 1; iss_reg = 2;
        cycle();
        idle_inputs();
        cycle();

        // asynchronous reset mid-cycle with a write in flight
        issue(2'd2);
        a_valid = 1; a_reg = 2; a_data = 16'h5A5A;
        cycle();
        idle_inputs();
        #1 rst_n = 0;
        #1;
        chk("async_rf_we", rf_we, 1'b0);
        chk("async_rf_reg", rf_reg, 2'd0);
        chk("async_rf_data", rf_data, 16'h0);
        chk("async_busy", busy, 4'h0);
        model_reset();
        rst_n = 1;
        a_valid = 1; b_valid = 1; a_data = 16'h0A0A; b_data = 16'h0B0B;
        cycle();
        chk("post_reset_tie_a", g_a, 1'b1);
        idle_inputs();
        cycle();

        // random traffic; producers hold until granted
        for (int n = 0; n < 500; n++) begin
            iss_valid = ($urandom_range(0, 2) == 0);
            iss_reg   = 2'($urandom);
            rd_reg1   = 2'($urandom);
            rd_reg2   = 2'($urandom);
            flush     = ($urandom_range(0, 24) == 0);
            cycle();
            if (!a_valid || g_a) begin
                a_valid = $urandom_range(0, 1) == 1;
                a_reg = 2'($urandom); a_data = 16'($urandom);
            end
            if (!b_valid || g_b) begin
                b_valid = $urandom_range(0, 1) == 1;
                b_reg = 2'($urandom); b_data = 16'($urandom);
            end
        end
        idle_inputs();
        cycle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
